// File: rtl/mdu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mdu : iterative MULT/DIV unit with HI/LO registers, one bit per cycle.   |
// | Divide datapath present only when MDU_DIV_EN is defined.                 |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dbz
);

    localparam int c_CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_CW-1:0]    r_cnt;
    logic [2*WIDTH-1:0] r_p;      // mult: {partial, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   r_m;
    logic               r_neg;
    logic               r_busy;
    logic               r_done;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_is_mul;
    logic               w_is_div;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_msum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_next;

    // Signed ops work on magnitudes; the sign is restored on the final step.
    assign w_is_mul = (op[2:1] == 2'b00);
    assign w_a_neg  = op[0] & a[WIDTH-1];
    assign w_b_neg  = op[0] & b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;

    assign w_msum     = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_m} : '0);
    assign w_mul_next = {w_msum, r_p[WIDTH-1:1]};
    assign w_prod     = r_neg ? -w_mul_next : w_mul_next;

`ifdef MDU_DIV_EN
    logic               r_div;
    logic               r_sgn;
    logic               r_rneg;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_div_next;
    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_r;

    // Restoring step; a zero divisor never borrows, giving all-ones / dividend.
    assign w_is_div   = (op[2:1] == 2'b01);
    assign w_shift    = r_p[2*WIDTH-1:WIDTH-1];
    assign w_diff     = w_shift - {1'b0, r_m};
    assign w_div_next = w_diff[WIDTH] ? {w_shift[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0}
                                      : {w_diff[WIDTH-1:0],  r_p[WIDTH-2:0], 1'b1};
    assign w_q        = r_neg  ? -w_div_next[WIDTH-1:0]       : w_div_next[WIDTH-1:0];
    assign w_r        = r_rneg ? -w_div_next[2*WIDTH-1:WIDTH] : w_div_next[2*WIDTH-1:WIDTH];
    assign w_next     = r_div ? w_div_next : w_mul_next;
`else
    assign w_is_div   = 1'b0;
    assign w_next     = w_mul_next;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_p     <= '0;
            r_m     <= '0;
            r_neg   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
`ifdef MDU_DIV_EN
            r_div   <= 1'b0;
            r_sgn   <= 1'b0;
            r_rneg  <= 1'b0;
`endif
        end else if (r_state == S_RUN) begin
            r_p <= w_next;
            if (r_cnt == '0) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
`ifdef MDU_DIV_EN
                if (r_div) begin
                    r_dbz <= (r_m == '0);
                    if (!(r_sgn && (r_m == '0))) begin
                        r_hi <= w_r;
                        r_lo <= w_q;
                    end
                end else
`endif
                begin
                    r_hi <= w_prod[2*WIDTH-1:WIDTH];
                    r_lo <= w_prod[WIDTH-1:0];
                end
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end else begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            if (start) begin
                if (w_is_mul || w_is_div) begin
                    r_state <= S_RUN;
                    r_busy  <= 1'b1;
                    r_dbz   <= 1'b0;
                    r_cnt   <= c_CW'(WIDTH - 1);
                    r_neg   <= w_a_neg ^ w_b_neg;
`ifdef MDU_DIV_EN
                    r_div   <= w_is_div;
                    r_sgn   <= op[0];
                    r_rneg  <= w_a_neg;
                    if (w_is_div) begin
                        r_p <= {{WIDTH{1'b0}}, w_a_mag};
                        r_m <= w_b_mag;
                    end else
`endif
                    begin
                        r_p <= {{WIDTH{1'b0}}, w_b_mag};
                        r_m <= w_a_mag;
                    end
                end else if (op == 3'd4) begin
                    r_hi <= a;
                end else if (op == 3'd5) begin
                    r_lo <= a;
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;
    assign dbz  = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// tb_mdu: randomized + directed self-checking bench for mdu against a
// cycle-level behavioural model using native arithmetic.
module tb_mdu;
    localparam int W = 32;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mdu #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo),
        .dbz   (dbz)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit           m_busy, m_done, m_dbz, chk_on;
    logic [W-1:0] m_hi, m_lo;
    int           m_left;
    bit           p_wr, p_dbz;
    logic [W-1:0] p_hi, p_lo;

    task automatic compute(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [63:0] p;
        int sx, sy;
        sx = x;
        sy = y;
        p_wr  = 1'b1;
        p_dbz = 1'b0;
        case (o)
            3'd0: p = {32'b0, x} * {32'b0, y};
            3'd1: p = longint'(sx) * longint'(sy);
            3'd2: begin
                if (y == 0) begin
                    p_dbz = 1'b1;
                    p = {x, 32'hFFFF_FFFF};
                end else begin
                    p = {x % y, x / y};
                end
            end
            default: begin
                if (y == 0) begin
                    p_dbz = 1'b1;
                    p_wr  = 1'b0;
                    p = '0;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    p = {32'h0, 32'h8000_0000};
                end else begin
                    p = {32'(sx % sy), 32'(sx / sy)};
                end
            end
        endcase
        p_hi = p[63:32];
        p_lo = p[31:0];
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0; m_done = 0; m_dbz = 0; m_hi = '0; m_lo = '0; m_left = 0;
            chk_on = 1;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0;
                m_done = 1;
                m_dbz  = p_dbz;
                if (p_wr) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                end
            end
        end else begin
            m_done = 0;
            if (start) begin
                if (op <= 3'd1 || (DIV_EN && (op == 3'd2 || op == 3'd3))) begin
                    compute(op, a, b);
                    m_busy = 1;
                    m_left = W;
                    m_dbz  = 0;
                end else if (op == 3'd4) begin
                    m_hi = a;
                end else if (op == 3'd5) begin
                    m_lo = a;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("dbz",  dbz,  m_dbz);
            chk("hi",   hi,   m_hi);
            chk("lo",   lo,   m_lo);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int nb, output int ncyc);
        nb = 0;
        ncyc = 1;
        for (int k = 0; k < 80; k++) begin
            if (done) return;
            if (busy) nb++;
            ncyc++;
            @(negedge clk);
        end
        chk("timeout_done", done, 1);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return W'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int nb, nc;
        chk_on = 0;
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_dbz", dbz, 0);
        reset = 1'b0;

        issue(3'd0, 32'hFFFF_FFFF, 32'd2);
        wait_done(nb, nc);
        chk("multu_busy_cycles", nb, 32);
        chk("multu_done_cycle", nc, 33);
        chk("multu_hi", hi, 32'h1);
        chk("multu_lo", lo, 32'hFFFF_FFFE);
        chk("model_multu_lo", m_lo, 32'hFFFF_FFFE);

        issue(3'd1, 32'hFFFF_FFFD, 32'd5);
        wait_done(nb, nc);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFF1);
        chk("model_mult_lo", m_lo, 32'hFFFF_FFF1);
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
`ifdef MDU_DIV_EN
        wait_done(nb, nc);
        chk("div_b2b_lo", lo, 32'hFFFF_FFFD);
        chk("div_b2b_hi", hi, 32'hFFFF_FFFF);
        chk("model_div_lo", m_lo, 32'hFFFF_FFFD);

        issue(3'd2, 32'd5, 32'd0);
        wait_done(nb, nc);
        chk("divu0_dbz", dbz, 1);
        chk("divu0_lo", lo, 32'hFFFF_FFFF);
        chk("divu0_hi", hi, 32'd5);
        issue(3'd0, 32'd2, 32'd3);
        chk("dbz_clear_on_accept", dbz, 0);
        wait_done(nb, nc);
        chk("mul23_lo", lo, 32'd6);
        chk("mul23_hi", hi, 32'd0);

        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(nb, nc);
        chk("divmin_lo", lo, 32'h8000_0000);
        chk("divmin_hi", hi, 32'd0);
        chk("divmin_dbz", dbz, 0);

        issue(3'd3, 32'd9, 32'd0);
        wait_done(nb, nc);
        chk("div0_dbz", dbz, 1);
        chk("div0_lo_kept", lo, 32'h8000_0000);
`else
        chk("nodiv_busy", busy, 0);
        chk("nodiv_done", done, 0);
        chk("nodiv_hi", hi, 32'hFFFF_FFFF);
        chk("nodiv_lo", lo, 32'hFFFF_FFF1);
`endif

        issue(3'd0, 32'd7, 32'd9);
        tick(3);
        start = 1'b1; op = 3'd5; a = 32'h55; b = '0;
        tick(1);
        start = 1'b0;
        wait_done(nb, nc);
        chk("ignored_start_lo", lo, 32'd63);
        chk("ignored_start_hi", hi, 32'd0);

        issue(3'd0, 32'd3, 32'd4);
        tick(9);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        for (int k = 0; k < 36; k++) begin
            tick(1);
            chk("abort_no_done", done, 0);
        end

        issue(3'd4, 32'h1234, 32'd0);
        chk("mthi_hi", hi, 32'h1234);
        chk("mthi_busy", busy, 0);
        chk("mthi_done", done, 0);

        issue(3'd2, 32'd8, 32'd2);
`ifndef MDU_DIV_EN
        for (int k = 0; k < 3; k++) begin
            chk("divu_nop_busy", busy, 0);
            chk("divu_nop_done", done, 0);
            chk("divu_nop_hi", hi, 32'h1234);
            chk("divu_nop_lo", lo, 32'd0);
            tick(1);
        end
`else
        wait_done(nb, nc);
        chk("divu82_lo", lo, 32'd4);
        chk("divu82_hi", hi, 32'd0);
`endif

        for (int k = 0; k < 4000; k++) begin
            reset = ($urandom_range(0, 399) == 0);
            start = ($urandom_range(0, 3) == 0);
            op    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            a     = pick();
            b     = pick();
            tick(1);
        end
        reset = 1'b0;
        start = 1'b0;
        tick(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; legal values are even integers >= 4.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 start  input  1  request strobe, sampled on rising clk.
REQ-005 op  input  3  0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MTHI, 5 MTLO, 6-7 no-op.
REQ-006 a  input  WIDTH  multiplicand/dividend, or data for MTHI/MTLO.
REQ-007 b  input  WIDTH  multiplier/divisor.
REQ-008 busy  output  1  high while an iterative operation is in progress.
REQ-009 done  output  1  one-cycle pulse marking the cycle after hi/lo receive a mult/div result.
REQ-010 hi  output  WIDTH  HI register: product upper half or remainder.
REQ-011 lo  output  WIDTH  LO register: product lower half or quotient.
REQ-012 dbz  output  1  divide-by-zero flag for the most recent divide.

Function
REQ-013 States are IDLE, RUN and DONE; busy=1 only in RUN, and done=1 only in DONE.
REQ-014 Start is accepted only in IDLE or DONE; start in RUN is ignored with no effect on state, hi, lo or dbz.
REQ-015 An accepted op 0-3 latches a, b and op at acceptance edge E0, enters RUN, clears dbz and loads iteration counter to WIDTH-1.
REQ-016 RUN performs one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle for exactly WIDTH cycles.
REQ-017 At edge E0+WIDTH the final step completes, the sign fix-up is applied, hi/lo are written, and state goes to DONE.
REQ-018 DONE lasts one cycle, then goes to IDLE unless a start is accepted there; a start accepted in DONE enters RUN, giving back-to-back operation.
REQ-019 MULTU: {hi,lo} = unsigned a*b, full 2*WIDTH-bit product.
REQ-020 MULT: {hi,lo} = two's-complement a*b, full 2*WIDTH-bit signed product.
REQ-021 DIVU: lo = a/b and hi = a%b, unsigned.
REQ-022 DIV: signed; quotient truncates toward zero and the remainder takes the sign of the dividend.
REQ-023 DIV with a = most-negative and b = -1: lo = most-negative, hi = 0, dbz = 0 (wrap, no trap).
REQ-024 Divide with b = 0 takes the full latency and sets dbz = 1; DIVU gives lo = all ones, hi = a.
REQ-025 DIV with b = 0 sets dbz = 1 and leaves hi and lo unchanged.
REQ-026 dbz holds its value until the next accepted op 0-3 or reset.
REQ-027 MTHI/MTLO accepted in IDLE/DONE write a to hi/lo at the acceptance edge; no busy, no done, and state goes to IDLE.
REQ-028 Ops 6-7 accepted in IDLE/DONE have no effect except DONE->IDLE.
REQ-029 hi and lo hold their values except on the writes defined in REQ-017, REQ-025 and REQ-027; they are never corrupted during RUN.

Reset
REQ-030 On reset: state = IDLE, busy = 0, done = 0, dbz = 0, hi = 0, lo = 0, counter = 0.
REQ-031 Reset has priority over start and aborts any operation in RUN immediately, with no result write.
REQ-032 A start asserted in the same cycle as reset is discarded.

Configuration
REQ-033 Macro MDU_DIV_EN defined: the divide datapath is compiled in and ops 2-3 behave per REQ-021 to REQ-026.
REQ-034 MDU_DIV_EN undefined: no divide logic exists; ops 2-3 behave as no-ops per REQ-028 and dbz is tied to 0.

Verification
REQ-035 WIDTH=32, MULTU a=0xFFFFFFFF b=2 -> busy for 32 cycles, done at cycle 33 after acceptance, hi=0x00000001, lo=0xFFFFFFFE.
REQ-036 MULT a=-3 b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; then DIV a=-7 b=2 started in DONE -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-037 DIVU a=5 b=0 -> dbz=1, lo=0xFFFFFFFF, hi=5; following MULTU 2*3 -> dbz=0, lo=6, hi=0.
REQ-038 DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0, dbz=0.
REQ-039 MULTU 7*9 with start pulsed again at RUN cycle 5 using op=MTLO a=0x55 -> second start ignored, lo=63 at done; reset at RUN cycle 10 of the next op -> all outputs 0 the following cycle, no done pulse.
REQ-040 MTHI a=0x1234 in IDLE -> hi=0x1234 next cycle, busy and done stay 0; with MDU_DIV_EN undefined, DIVU 8/2 -> no busy, no done, hi and lo unchanged.
